// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;

  localparam int DATA_WIDTH_DEF = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational cyclic picker: first request at/after i_ptr wins, one-hot grant out.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_vld
);
  always_comb begin
    o_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if ((o_gnt == '0) && i_req[IW'((int'(i_ptr) + k) % NUM_REQ)])
        o_gnt[IW'((int'(i_ptr) + k) % NUM_REQ)] = 1'b1;
    end
  end

  assign o_vld = |i_req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-locked write-port arbiter for the async FIFO write domain.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_FRAME  = 16,
  localparam int IW        = idx_w(NUM_REQ),
  localparam int CW        = idx_w(MAX_FRAME)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          owner_vld,
  output logic [IW-1:0]                 owner_id
);
  arb_state_e          r_state;
  logic [IW-1:0]       r_owner;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       w_ptr;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_pick_vld;
  logic [IW-1:0]       w_win_idx;
  logic                w_oreq, w_olast, w_wr, w_release;
  logic [DATA_WIDTH-1:0] w_odata;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_vld (w_pick_vld)
  );

  always_comb begin
    w_win_idx = '0;
    w_oreq    = 1'b0;
    w_olast   = 1'b0;
    w_odata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_win_idx = IW'(i);
      if (r_owner == IW'(i)) begin
        w_oreq  = req[i];
        w_olast = last[i];
        w_odata = data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_wr      = (r_state == LOCKED) && w_oreq && !wfull;
  assign w_release = w_wr && (w_olast || (r_cnt == CW'(MAX_FRAME - 1)));

  assign winc      = w_wr;
  assign wdata     = (r_state == LOCKED) ? w_odata : '0;
  assign owner_vld = (r_state == LOCKED);
  assign owner_id  = r_owner;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_wr && (r_owner == IW'(i))) ack[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_state <= LOCKED;
          r_owner <= w_win_idx;
          r_cnt   <= '0;
        end
        LOCKED: if (w_release) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (w_wr) begin
          r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  // Next search starts just past the requester that last released.
  logic [IW-1:0] r_ptr;
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_release)
      r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
  end
  assign w_ptr = r_ptr;
`endif
endmodule
